sobel_window_core: RTL and testbench

Consumes the three row taps produced by the double line buffer (newest, middle and oldest row, qualified by its done strobe). It assembles a sliding 3x3 window, computes the Sobel gradient magnitude |Gx|+|Gy| saturated to 8 bits, and emits one processed pixel per complete window. It sits directly downstream of the line buffer in the Sobel filter datapath and feeds the output pixel writer.

---
 rtl/sobel_window_core_if.sv | 22 ++
 rtl/sobel_window_core.sv | 126 ++++++++++++
 tb/tb_sobel_window_core.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sobel_window_core_if.sv
// Column-tap input and processed-pixel output of the Sobel window core.
// The core takes the slave view; whoever feeds it and collects results takes the master view.
interface sobel_window_core_if;
    logic       valid_i;
    logic [7:0] data0_i;
    logic [7:0] data1_i;
    logic [7:0] data2_i;
    logic       valid_o;
    logic [7:0] pixel_o;
    logic       eol_o;
    logic       eof_o;

    modport master (
        output valid_i, data0_i, data1_i, data2_i,
        input  valid_o, pixel_o, eol_o, eof_o
    );

    modport slave (
        input  valid_i, data0_i, data1_i, data2_i,
        output valid_o, pixel_o, eol_o, eof_o
    );
endinterface

// File: rtl/sobel_window_core.sv
// Sliding 3x3 window over the line-buffer taps with a 3-stage Sobel |Gx|+|Gy| pipeline.
// Produces one saturated 8-bit pixel per complete window, with end-of-line/frame flags.
module sobel_window_core #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic              clk,
    input  logic              rst,
    sobel_window_core_if.slave bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int LW = $clog2(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(IMG_HEIGHT - 2);

    logic [CW-1:0]         col_cnt_q, col_cnt_d;
    logic [LW-1:0]         line_cnt_q, line_cnt_d;
    logic [2:0][2:0][7:0]  win_q, win_d;
    logic                  v1_q, v1_d, eol1_q, eol1_d, eof1_q, eof1_d;
    logic signed [10:0]    gx_q, gx_d, gy_q, gy_d;
    logic                  v2_q, v2_d, eol2_q, eol2_d, eof2_q, eof2_d;
    logic [7:0]            pixel_q, pixel_d;
    logic                  valid_o_q, valid_o_d, eol_o_q, eol_o_d, eof_o_q, eof_o_d;

    logic                  complete;
    logic [9:0]            gx_pos, gx_neg, gy_pos, gy_neg;
    logic [10:0]           abs_x, abs_y;
    logic [11:0]           mag;

    // Stage 1: counters and window capture; win[r][c] with r0 = top row, c2 = newest column.
    always_comb begin
        col_cnt_d  = col_cnt_q;
        line_cnt_d = line_cnt_q;
        win_d      = win_q;
        v1_d       = 1'b0;
        eol1_d     = 1'b0;
        eof1_d     = 1'b0;
        complete   = (col_cnt_q >= CW'(2)) && (line_cnt_q != '0);
        if (bus.valid_i) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = bus.data2_i;
            win_d[1][2] = bus.data1_i;
            win_d[2][2] = bus.data0_i;
            v1_d   = complete;
            eol1_d = complete && (col_cnt_q == COL_LAST);
            eof1_d = complete && (col_cnt_q == COL_LAST) && (line_cnt_q == LINE_LAST);
            if (col_cnt_q == COL_LAST) begin
                col_cnt_d  = '0;
                line_cnt_d = (line_cnt_q == LINE_LAST) ? '0 : line_cnt_q + 1'b1;
            end else begin
                col_cnt_d = col_cnt_q + 1'b1;
            end
        end
    end

    // Stage 2: signed gradients, each the difference of two weighted 10-bit sums.
    always_comb begin
        gx_pos = {2'b0, win_q[0][2]} + {1'b0, win_q[1][2], 1'b0} + {2'b0, win_q[2][2]};
        gx_neg = {2'b0, win_q[0][0]} + {1'b0, win_q[1][0], 1'b0} + {2'b0, win_q[2][0]};
        gy_pos = {2'b0, win_q[2][0]} + {1'b0, win_q[2][1], 1'b0} + {2'b0, win_q[2][2]};
        gy_neg = {2'b0, win_q[0][0]} + {1'b0, win_q[0][1], 1'b0} + {2'b0, win_q[0][2]};
        gx_d   = signed'({1'b0, gx_pos}) - signed'({1'b0, gx_neg});
        gy_d   = signed'({1'b0, gy_pos}) - signed'({1'b0, gy_neg});
        v2_d   = v1_q;
        eol2_d = eol1_q;
        eof2_d = eof1_q;
    end

    // Stage 3: magnitude and saturation; flags are gated so they never appear without valid.
    always_comb begin
        abs_x     = gx_q[10] ? 11'(-gx_q) : 11'(gx_q);
        abs_y     = gy_q[10] ? 11'(-gy_q) : 11'(gy_q);
        mag       = {1'b0, abs_x} + {1'b0, abs_y};
        pixel_d   = pixel_q;
        if (v2_q) begin
            pixel_d = (mag > 12'd255) ? 8'd255 : mag[7:0];
        end
        valid_o_d = v2_q;
        eol_o_d   = v2_q && eol2_q;
        eof_o_d   = v2_q && eof2_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt_q  <= '0;
            line_cnt_q <= '0;
            win_q      <= '0;
            v1_q       <= 1'b0;
            eol1_q     <= 1'b0;
            eof1_q     <= 1'b0;
            gx_q       <= '0;
            gy_q       <= '0;
            v2_q       <= 1'b0;
            eol2_q     <= 1'b0;
            eof2_q     <= 1'b0;
            pixel_q    <= '0;
            valid_o_q  <= 1'b0;
            eol_o_q    <= 1'b0;
            eof_o_q    <= 1'b0;
        end else begin
            col_cnt_q  <= col_cnt_d;
            line_cnt_q <= line_cnt_d;
            win_q      <= win_d;
            v1_q       <= v1_d;
            eol1_q     <= eol1_d;
            eof1_q     <= eof1_d;
            gx_q       <= gx_d;
            gy_q       <= gy_d;
            v2_q       <= v2_d;
            eol2_q     <= eol2_d;
            eof2_q     <= eof2_d;
            pixel_q    <= pixel_d;
            valid_o_q  <= valid_o_d;
            eol_o_q    <= eol_o_d;
            eof_o_q    <= eof_o_d;
        end
    end

    assign bus.valid_o = valid_o_q;
    assign bus.pixel_o = pixel_q;
    assign bus.eol_o   = eol_o_q;
    assign bus.eof_o   = eof_o_q;
endmodule

// File: tb/tb_sobel_window_core.sv
// Randomized bench for sobel_window_core: feeds whole images as line-buffer taps and
// compares every output pixel, flag and latency against a direct Sobel model of the image.
module tb_sobel_window_core;
    localparam int W = 8;
    localparam int H = 6;

    typedef struct {
        int     pix;
        int     eol;
        int     eof;
        longint cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     tests_run = 0;
    int     tests_failed = 0;
    longint cyc = 0;
    int     img [H][W];
    exp_t   exp_q [$];
    exp_t   mon_e;
    int     valid_count = 0;
    int     eol_count = 0;
    int     eof_count = 0;

    sobel_window_core_if bus ();

    sobel_window_core #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input int got, input int expv);
        tests_run++;
        if (got !== expv) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    function automatic int sobel_ref(input int r, input int c);
        int gx, gy, mag;
        gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
        gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (mag > 255) ? 255 : mag;
    endfunction

    // Image patterns: flat, vertical edge, saturating vertical edge, horizontal edge, random.
    task automatic fillImage(input int mode);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (mode)
                    0:       img[r][c] = 8'h80;
                    1:       img[r][c] = (c < 4) ? 0 : 20;
                    2:       img[r][c] = (c < 4) ? 0 : 255;
                    3:       img[r][c] = (r == 0) ? 0 : 100;
                    default: img[r][c] = int'($urandom_range(255));
                endcase
            end
        end
    endtask

    task automatic clearCounts();
        valid_count = 0;
        eol_count   = 0;
        eof_count   = 0;
    endtask

    // Line L carries rows L+1 (newest), L and L-1 (oldest); stops before beat (stop_line, stop_col).
    task automatic applyStimulus(input int gap_pct, input int stop_line, input int stop_col);
        exp_t e;
        for (int l = 0; l < H - 1; l++) begin
            for (int c = 0; c < W; c++) begin
                if (l == stop_line && c == stop_col) begin
                    bus.valid_i = 1'b0;
                    return;
                end
                if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                    repeat ($urandom_range(1, 5)) begin
                        bus.valid_i = 1'b0;
                        bus.data0_i = 8'($urandom_range(255));
                        bus.data1_i = 8'($urandom_range(255));
                        bus.data2_i = 8'($urandom_range(255));
                        @(posedge clk);
                        #1;
                    end
                end
                bus.valid_i = 1'b1;
                bus.data0_i = 8'(img[l+1][c]);
                bus.data1_i = 8'(img[l][c]);
                bus.data2_i = (l == 0) ? 8'($urandom_range(255)) : 8'(img[l-1][c]);
                if (l >= 1 && c >= 2) begin
                    e.pix = sobel_ref(l, c - 1);
                    e.eol = (c == W - 1) ? 1 : 0;
                    e.eof = (c == W - 1 && l == H - 2) ? 1 : 0;
                    e.cyc = cyc + 1;
                    exp_q.push_back(e);
                end
                @(posedge clk);
                #1;
            end
        end
        bus.valid_i = 1'b0;
    endtask

    task automatic drainAndCount(input string tag, input int n_valid, input int n_eol, input int n_eof);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        checkOutput({tag, "_drain"}, exp_q.size(), 0);
        checkOutput({tag, "_valid_count"}, valid_count, n_valid);
        checkOutput({tag, "_eol_count"}, eol_count, n_eol);
        checkOutput({tag, "_eof_count"}, eof_count, n_eof);
        exp_q.delete();
        clearCounts();
    endtask

    always @(negedge clk) begin
        if (bus.valid_o === 1'b1) begin
            valid_count++;
            if (bus.eol_o === 1'b1) eol_count++;
            if (bus.eof_o === 1'b1) eof_count++;
            if (exp_q.size() == 0) begin
                checkOutput("extra_pixel", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("pixel", int'(bus.pixel_o), mon_e.pix);
                checkOutput("eol", int'(bus.eol_o), mon_e.eol);
                checkOutput("eof", int'(bus.eof_o), mon_e.eof);
                checkOutput("latency", int'(cyc - mon_e.cyc), 2);
            end
        end else if (rst === 1'b1) begin
            checkOutput("eol_idle", int'(bus.eol_o), 0);
            checkOutput("eof_idle", int'(bus.eof_o), 0);
        end
    end

    initial begin
        bus.valid_i = 1'b0;
        bus.data0_i = '0;
        bus.data1_i = '0;
        bus.data2_i = '0;
        #1 rst = 1'b0;
        #2;
        checkOutput("reset_valid", int'(bus.valid_o), 0);
        checkOutput("reset_pixel", int'(bus.pixel_o), 0);
        checkOutput("reset_eol", int'(bus.eol_o), 0);
        checkOutput("reset_eof", int'(bus.eof_o), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        for (int mode = 0; mode < 5; mode++) begin
            fillImage(mode);
            applyStimulus(0, -1, -1);
            drainAndCount($sformatf("mode%0d", mode), 24, 4, 1);
        end

        fillImage(4);
        applyStimulus(0, -1, -1);
        drainAndCount("rand_gapless", 24, 4, 1);
        applyStimulus(40, -1, -1);
        drainAndCount("rand_gaps", 24, 4, 1);

        fillImage(2);
        applyStimulus(0, 2, 5);
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_valid", int'(bus.valid_o), 0);
        checkOutput("midrst_pixel", int'(bus.pixel_o), 0);
        checkOutput("midrst_eol", int'(bus.eol_o), 0);
        checkOutput("midrst_eof", int'(bus.eof_o), 0);
        exp_q.delete();
        clearCounts();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        fillImage(4);
        applyStimulus(0, -1, -1);
        drainAndCount("after_reset", 24, 4, 1);

        fillImage(4);
        applyStimulus(0, -1, -1);
        fillImage(3);
        applyStimulus(0, -1, -1);
        drainAndCount("back_to_back", 48, 8, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
